// File: rtl/pool2x2_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : pool2x2_stream_engine
// Brief    : 2x2 stride-2 max/average pooling over a channel-interleaved
//            raster stream with ready/valid handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module pool2x2_stream_engine #(
    parameter int DATA_W     = 8,
    parameter int MAP_WIDTH  = 28,
    parameter int MAP_HEIGHT = 28,
    parameter int CHANNELS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] out_data_o,
    output logic                     out_last_o,
    output logic                     frame_done_o
);

    localparam int c_ch_w     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_col_w    = $clog2(MAP_WIDTH);
    localparam int c_row_w    = $clog2(MAP_HEIGHT);
    localparam int c_lb_depth = (MAP_WIDTH / 2) * CHANNELS;
    localparam int c_idx_w    = (c_lb_depth > 1) ? $clog2(c_lb_depth) : 1;

    localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHANNELS - 1);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(MAP_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(MAP_HEIGHT - 1);
    // The last complete window ends on the last odd column/row; an odd
    // trailing column or row is consumed without producing output.
    localparam logic [c_col_w-1:0] c_col_win_last = c_col_w'(2 * (MAP_WIDTH / 2) - 1);
    localparam logic [c_row_w-1:0] c_row_win_last = c_row_w'(2 * (MAP_HEIGHT / 2) - 1);

    logic [c_ch_w-1:0]        ch_q, ch_d;
    logic [c_col_w-1:0]       col_q, col_d;
    logic [c_row_w-1:0]       row_q, row_d;
    logic                     mode_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_last_q;
    logic                     frame_done_q;

    logic signed [DATA_W-1:0] hold_q [CHANNELS];
    logic signed [DATA_W:0]   lb_q   [c_lb_depth];

    logic                     w_accept;
    logic                     w_complete;
    logic                     w_frame_last;
    logic [c_idx_w-1:0]       w_lb_idx;
    logic signed [DATA_W-1:0] w_hold;
    logic signed [DATA_W-1:0] w_max2;
    logic signed [DATA_W-1:0] w_max_fin;
    logic signed [DATA_W-1:0] w_result;
    logic signed [DATA_W:0]   w_lb;
    logic signed [DATA_W:0]   w_sum2;
    logic signed [DATA_W:0]   w_part;
    logic signed [DATA_W+1:0] w_sum4;

    assign in_ready_o   = !out_valid_q || out_ready_i;
    assign w_accept     = in_valid_i && in_ready_o;
    assign w_complete   = w_accept && col_q[0] && row_q[0];
    assign w_frame_last = (ch_q == c_ch_last) && (col_q == c_col_win_last)
                          && (row_q == c_row_win_last);

    always_comb begin
        ch_d  = ch_q;
        col_d = col_q;
        row_d = row_q;
        if (w_accept) begin
            if (ch_q == c_ch_last) begin
                ch_d = '0;
                if (col_q == c_col_last) begin
                    col_d = '0;
                    row_d = (row_q == c_row_last) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                ch_d = ch_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_lb_idx = '0;
        if (col_q[0]) begin
            w_lb_idx = c_idx_w'(int'(col_q >> 1) * CHANNELS + int'(ch_q));
        end
        w_hold    = hold_q[ch_q];
        w_lb      = lb_q[w_lb_idx];
        w_max2    = (w_hold > in_data_i) ? w_hold : in_data_i;
        w_sum2    = {w_hold[DATA_W-1], w_hold} + {in_data_i[DATA_W-1], in_data_i};
        w_part    = mode_q ? w_sum2 : {w_max2[DATA_W-1], w_max2};
        w_max_fin = (w_lb > w_part) ? w_lb[DATA_W-1:0] : w_max2;
        w_sum4    = {w_sum2[DATA_W], w_sum2} + {w_lb[DATA_W], w_lb};
        // Arithmetic shift floors toward -inf; a 4-sample mean always fits DATA_W.
        w_result  = mode_q ? DATA_W'(w_sum4 >>> 2) : w_max_fin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q         <= '0;
            col_q        <= '0;
            row_q        <= '0;
            mode_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            ch_q  <= ch_d;
            col_q <= col_d;
            row_q <= row_d;
            if (w_accept && (ch_q == '0) && (col_q == '0) && (row_q == '0)) begin
                mode_q <= mode_i;
            end
            frame_done_q <= out_valid_q && out_ready_i && out_last_q;
            if (w_complete) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_result;
                out_last_q  <= w_frame_last;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Window storage needs no reset: every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (!col_q[0]) begin
                hold_q[ch_q] <= in_data_i;
            end else if (!row_q[0]) begin
                lb_q[w_lb_idx] <= w_part;
            end
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_last_o   = out_last_q;
    assign frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool2x2_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool2x2_stream_engine
// Brief    : Self-checking bench for pool2x2_stream_engine over several
//            geometries, compared against a frame-level pooling model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool2x2_stream_engine;

    function automatic int cfg_w(input int k);
        case (k)
            0: return 4;
            1: return 2;
            2: return 2;
            3: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_h(input int k);
        case (k)
            0: return 4;
            1: return 2;
            2: return 2;
            3: return 5;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_c(input int k);
        case (k)
            2: return 2;
            4: return 3;
            default: return 1;
        endcase
    endfunction

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic              in_valid;
    logic              out_ready;
    logic signed [7:0] in_data;
    logic [2:0]        sel;

    logic              iv_k [5];
    logic              or_k [5];
    logic              ir   [5];
    logic              ov   [5];
    logic              ol   [5];
    logic              fd   [5];
    logic signed [7:0] od   [5];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        assign iv_k[g] = in_valid && (sel == 3'(g));
        assign or_k[g] = (sel == 3'(g)) ? out_ready : 1'b1;
        pool2x2_stream_engine #(
            .DATA_W    (8),
            .MAP_WIDTH (cfg_w(g)),
            .MAP_HEIGHT(cfg_h(g)),
            .CHANNELS  (cfg_c(g))
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .mode_i      (mode),
            .in_valid_i  (iv_k[g]),
            .in_ready_o  (ir[g]),
            .in_data_i   (in_data),
            .out_valid_o (ov[g]),
            .out_ready_i (or_k[g]),
            .out_data_o  (od[g]),
            .out_last_o  (ol[g]),
            .frame_done_o(fd[g])
        );
    end

    logic              ir_s, ov_s, ol_s, fd_s;
    logic signed [7:0] od_s;
    assign ir_s = ir[sel];
    assign ov_s = ov[sel];
    assign ol_s = ol[sel];
    assign fd_s = fd[sel];
    assign od_s = od[sel];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: collects consumed outputs and tracks frame_done timing.
    int   got_d [$];
    bit   got_l [$];
    int   got_c [$];
    int   fd_cnt = 0;
    int   fd_bad = 0;
    logic exp_fd = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_fd <= 1'b0;
        end else begin
            if (ov_s && out_ready) begin
                got_d.push_back(int'(od_s));
                got_l.push_back(ol_s);
                got_c.push_back(cyc);
            end
            if (fd_s) fd_cnt <= fd_cnt + 1;
            if (fd_s !== exp_fd) fd_bad <= fd_bad + 1;
            exp_fd <= ov_s && out_ready && ol_s;
        end
    end

    int frame [$];
    int exp_d [$];
    bit exp_l [$];
    int acc_c [$];
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        vec_cnt++;
        assert (obs === expv) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rand_sample();
        if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) != 0) ? 127 : -128;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Reference: pool each complete 2x2 window straight from the frame array.
    task automatic build_expected(input int k, input bit md);
        int w, h, c, a, b, d, e, s, res;
        w = cfg_w(k);
        h = cfg_h(k);
        c = cfg_c(k);
        exp_d.delete();
        exp_l.delete();
        for (int r = 0; r < h / 2; r++) begin
            for (int q = 0; q < w / 2; q++) begin
                for (int ch = 0; ch < c; ch++) begin
                    a = frame[((2 * r) * w + 2 * q) * c + ch];
                    b = frame[((2 * r) * w + 2 * q + 1) * c + ch];
                    d = frame[((2 * r + 1) * w + 2 * q) * c + ch];
                    e = frame[((2 * r + 1) * w + 2 * q + 1) * c + ch];
                    if (md) begin
                        s   = a + b + d + e;
                        res = (s >= 0) ? s / 4 : -((-s + 3) / 4);
                    end else begin
                        res = a;
                        if (b > res) res = b;
                        if (d > res) res = d;
                        if (e > res) res = e;
                    end
                    exp_d.push_back(res);
                    exp_l.push_back((r == h / 2 - 1) && (q == w / 2 - 1) && (ch == c - 1));
                end
            end
        end
    endtask

    task automatic send(input int k, input bit md, input int first, input int last_i,
                        input bit gaps, input bit stalls, input bit toggle);
        bit acc;
        int t;
        sel = 3'(k);
        for (int i = first; i < last_i; i++) begin
            acc     = 1'b0;
            t       = 0;
            in_data = 8'(frame[i]);
            mode    = (i == 0 || !toggle) ? md : 1'($urandom);
            while (!acc && t < 200) begin
                in_valid = !(gaps && ($urandom_range(0, 3) == 0));
                if (stalls) out_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                acc = in_valid && ir_s;
                if (acc) acc_c.push_back(cyc);
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) chk("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int base, input int n, input bit stalls);
        int t;
        t = 0;
        while ((got_d.size() - base) < n && t < 400) begin
            out_ready = !(stalls && ($urandom_range(0, 2) == 0));
            @(posedge clk);
            #1;
            t++;
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (t >= 400) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input int base, input int fd0);
        int n;
        n = got_d.size() - base;
        chk({tag, "_count"}, n, exp_d.size());
        for (int i = 0; i < exp_d.size() && i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[base + i], exp_d[i]);
            chk($sformatf("%s_last%0d", tag, i), int'(got_l[base + i]), int'(exp_l[i]));
        end
        chk({tag, "_frame_done"}, fd_cnt - fd0, 1);
        chk({tag, "_fd_timing"}, fd_bad, 0);
    endtask

    task automatic run_frame(input string tag, input int k, input bit md, input bit gaps,
                             input bit stalls, input bit toggle, output int base);
        int fd0;
        base = got_d.size();
        fd0  = fd_cnt;
        build_expected(k, md);
        acc_c.delete();
        send(k, md, 0, frame.size(), gaps, stalls, toggle);
        drain(base, exp_d.size(), stalls);
        check_frame(tag, base, fd0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(ov_s), 0);
        chk("post_rst_ready", int'(ir_s), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, fd0, k, n;
        int win_idx [4];
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("rst_in_ready%0d", j), int'(ir[j]), 1);
            chk($sformatf("rst_out_valid%0d", j), int'(ov[j]), 0);
            chk($sformatf("rst_out_data%0d", j), int'(od[j]), 0);
            chk($sformatf("rst_out_last%0d", j), int'(ol[j]), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 5; j++) chk($sformatf("rst_frame_done%0d", j), int'(fd[j]), 0);
        @(posedge clk);
        #1;

        // 4x4 ramp, max: 5,7,13,15 with one-cycle latency.
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(i);
        run_frame("max4x4", 0, 1'b0, 1'b0, 1'b0, 1'b0, base);
        win_idx = '{5, 7, 13, 15};
        for (int i = 0; i < 4 && (base + i) < got_c.size(); i++) begin
            chk($sformatf("latency%0d", i), got_c[base + i], acc_c[win_idx[i]] + 1);
        end

        frame = '{1, 2, 3, 5};
        run_frame("avg_pos", 1, 1'b1, 1'b0, 1'b0, 1'b0, base);
        frame = '{-1, -2, -3, -5};
        run_frame("avg_neg", 1, 1'b1, 1'b0, 1'b0, 1'b0, base);
        frame = '{-128, -1, -128, -128};
        run_frame("max_ext", 1, 1'b0, 1'b0, 1'b0, 1'b0, base);
        frame = '{127, 127, 127, 127};
        run_frame("avg_127", 1, 1'b1, 1'b0, 1'b0, 1'b0, base);
        frame = '{-128, -128, -128, -128};
        run_frame("avg_m128", 1, 1'b1, 1'b0, 1'b0, 1'b0, base);
        frame = '{1, 10, 4, -3, 2, 7, 3, 9};
        run_frame("chan2", 2, 1'b0, 1'b0, 1'b0, 1'b0, base);

        // Backpressure: hold the first output for six cycles.
        frame.delete();
        for (int i = 0; i < 16; i++) frame.push_back(i);
        build_expected(0, 1'b0);
        base = got_d.size();
        fd0  = fd_cnt;
        out_ready = 1'b0;
        send(0, 1'b0, 0, 6, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd6;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(ir_s), 0);
            chk("bp_out_valid", int'(ov_s), 1);
            chk("bp_out_data", int'(od_s), 5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(0, 1'b0, 6, 16, 1'b0, 1'b0, 1'b0);
        drain(base, exp_d.size(), 1'b0);
        check_frame("backpressure", base, fd0);

        // Odd geometry: trailing column and row are discarded.
        frame.delete();
        for (int i = 0; i < 25; i++) frame.push_back(i);
        run_frame("odd5x5", 3, 1'b0, 1'b0, 1'b0, 1'b0, base);

        // Mid-frame reset, then full frames with mode toggled mid-frame.
        frame.delete();
        for (int i = 0; i < 25; i++) frame.push_back(rand_sample());
        send(3, 1'b1, 0, 12, 1'b1, 1'b0, 1'b1);
        pulse_reset();
        frame.delete();
        for (int i = 0; i < 25; i++) frame.push_back(rand_sample());
        run_frame("rst_5x5", 3, 1'b1, 1'b1, 1'b0, 1'b1, base);
        frame = '{9, 9};
        send(1, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        frame = '{4, 3, 2, 1};
        run_frame("rst_2x2", 1, 1'b0, 1'b0, 1'b0, 1'b1, base);

        // Randomised frames across all geometries with gaps and stalls.
        for (int it = 0; it < 15; it++) begin
            k = it % 5;
            n = cfg_w(k) * cfg_h(k) * cfg_c(k);
            frame.delete();
            for (int i = 0; i < n; i++) frame.push_back(rand_sample());
            run_frame($sformatf("rand%0d", it), k, 1'($urandom), 1'b1, 1'b1, 1'b1, base);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
